input_data_pipeline: RTL and testbench
======================================

INPUT_DATA_PIPELINE -- requirements
Module: input_data_pipeline

Interface
REQ-001 The module SHALL have parameter DataInputWidth, default 8, the data word width in bits.
REQ-002 The module SHALL have parameter Stages, default 5, the number of register stages; legal range 1..16.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 The module SHALL have port aclr, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port flush, input, 1 bit: synchronous discard of all held words.
REQ-006 The module SHALL have port DataIn, input, DataInputWidth bits: the upstream data word.
REQ-007 The module SHALL have port InValid, input, 1 bit: upstream asserts that DataIn holds a word.
REQ-008 The module SHALL have port InReady, output, 1 bit: the pipeline accepts a word this cycle.
REQ-009 The module SHALL have port DataOut, output, DataInputWidth bits: the word held in the last stage.
REQ-010 The module SHALL have port OutValid, output, 1 bit: the last stage holds a valid word.
REQ-011 The module SHALL have port OutReady, input, 1 bit: the downstream MAC consumes DataOut this cycle.
REQ-012 The module SHALL have port Count, output, clog2(Stages+1) bits: the number of valid stages.

Function
REQ-013 Each stage i (0..Stages-1) SHALL hold one data register and one valid bit; stage 0 SHALL be the input and stage Stages-1 SHALL be the output.
REQ-014 A transfer SHALL occur on an edge where the valid and ready signals of that side are both 1: InValid&InReady at the input, OutValid&OutReady at the output.
REQ-015 The last stage SHALL advance when it is empty or when OutReady=1.
REQ-016 Stage i<Stages-1 SHALL advance when it is empty or when stage i+1 advances, so bubbles collapse.
REQ-017 InReady SHALL equal the advance condition of stage 0, combinationally; InReady SHALL NOT depend on InValid.
REQ-018 When a stage advances, it SHALL load the data and valid bit of its predecessor (DataIn/InValid for stage 0).
REQ-019 A stage that does not advance SHALL hold its data and valid bit unchanged.
REQ-020 DataOut and OutValid SHALL be driven directly from the last-stage registers, with no combinational path from the inputs.
REQ-021 With the pipeline empty and OutReady=1, a word accepted on edge k SHALL appear with OutValid=1 after edge k+Stages-1.
REQ-022 With OutReady held 1, the pipeline SHALL sustain one transfer per cycle with no bubbles inserted.
REQ-023 Words SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 With all stages full and OutReady=0, InReady SHALL be 0; the output word SHALL stay stable and OutValid SHALL stay 1 until consumed.
REQ-025 In the full state, OutReady=1 together with InValid=1 SHALL consume one word and accept one word on the same edge, leaving Count unchanged at Stages.
REQ-026 Count SHALL be a register that increments on input-only transfers, decrements on output-only transfers, and holds otherwise; it SHALL never exceed Stages or wrap below 0.
REQ-027 Data registers whose valid bit is 0 SHALL be don't-care, but SHALL NOT be X after reset.
REQ-028 flush=1 SHALL clear all valid bits and Count on that edge.
REQ-029 While flush=1, InReady SHALL be 0, and any concurrent input or output handshake SHALL be discarded.

Reset
REQ-030 aclr=1 SHALL on that edge clear all valid bits, all data registers, and Count to 0, giving OutValid=0 and DataOut=0.
REQ-031 While aclr=1, InReady SHALL be 0.
REQ-032 aclr SHALL take priority over flush and over all handshakes.
REQ-033 A reset mid-stream SHALL discard all in-flight words.
REQ-034 The first accepted word after aclr deasserts SHALL follow REQ-021.

Verification
REQ-035 Stages=5, W=8, OutReady=1: send 0x11 on edge 0 -> OutValid=1, DataOut=0x11 after edge 4, Count=1 then 0.
REQ-036 Continuous InValid with data 0x00..0x3F, OutReady=1 -> 64 outputs, in order, on consecutive cycles, InReady never 0.
REQ-037 OutReady=0, send 7 words -> 5 accepted, InReady=0 after the 5th, Count=5, DataOut holds the 1st word; then OutReady=1 with InValid=1 -> one-in/one-out per edge with Count=5.
REQ-038 Fill 3 words, then OutReady toggling 1,0,1,0 with InValid=0 -> words emerge in order, each held while OutReady=0, Count reaches 0.
REQ-039 Pipeline holding 4 words, flush=1 for one edge with InValid=1 -> Count=0, OutValid=0, the flushed-cycle input is not accepted.
REQ-040 Pipeline holding 3 words, aclr=1 for one edge -> OutValid=0, DataOut=0, Count=0; the next word has 5-cycle latency.

Source files
------------

// File: rtl/input_data_pipeline.sv
// Elastic register pipeline with collapsing bubbles; a word reaches OutValid Stages-1 edges after acceptance.
// Backpressure: a stall ripples back only through full stages, so InReady drops only when every stage is full and OutReady=0.
module input_data_pipeline #(
    parameter int DataInputWidth = 8,
    parameter int Stages         = 5
) (
    input  logic                             clk,
    input  logic                             aclr,
    input  logic                             flush,
    input  logic [DataInputWidth-1:0]        DataIn,
    input  logic                             InValid,
    output logic                             InReady,
    output logic [DataInputWidth-1:0]        DataOut,
    output logic                             OutValid,
    input  logic                             OutReady,
    output logic [$clog2(Stages+1)-1:0]      Count
);

    localparam int CountWidth = $clog2(Stages+1);

    logic [DataInputWidth-1:0] stageData [Stages];
    logic [Stages-1:0]         stageValid;
    logic [Stages-1:0]         advance;
    logic                      advChain;
    logic                      inXfer;
    logic                      outXfer;

    // A stage may move if it is empty or everything downstream of it moves.
    always_comb begin
        advance  = '0;
        advChain = OutReady;
        for (int i = Stages - 1; i >= 0; i--) begin
            advChain   = !stageValid[i] || advChain;
            advance[i] = advChain;
        end
    end

    assign InReady  = advance[0] && !aclr && !flush;
    assign inXfer   = InValid && InReady;
    assign outXfer  = OutValid && OutReady && !aclr && !flush;
    assign DataOut  = stageData[Stages-1];
    assign OutValid = stageValid[Stages-1];

    always_ff @(posedge clk) begin
        if (aclr) begin
            stageValid <= '0;
            Count      <= '0;
            for (int i = 0; i < Stages; i++) begin
                stageData[i] <= '0;
            end
        end else if (flush) begin
            stageValid <= '0;
            Count      <= '0;
        end else begin
            if (advance[0]) begin
                stageValid[0] <= inXfer;
                if (inXfer) begin
                    stageData[0] <= DataIn;
                end
            end
            // Data only moves with a valid word; empty stages keep stale contents.
            for (int i = 1; i < Stages; i++) begin
                if (advance[i]) begin
                    stageValid[i] <= stageValid[i-1];
                    if (stageValid[i-1]) begin
                        stageData[i] <= stageData[i-1];
                    end
                end
            end
            if (inXfer && !outXfer) begin
                Count <= Count + CountWidth'(1);
            end else if (outXfer && !inXfer) begin
                Count <= Count - CountWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_input_data_pipeline.sv
// Self-checking bench: constant vector table, directed multi-cycle sequences, and random traffic
// compared against a queue-of-words model that tracks each word's position in the pipe.
module tb_input_data_pipeline;

    localparam int S = 5;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         aclr = 1'b1;
    logic         flush = 1'b0;
    logic [W-1:0] DataIn = '0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] DataOut;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [2:0]   Count;

    int nChecks = 0;
    int nErrors = 0;

    input_data_pipeline #(.DataInputWidth(W), .Stages(S)) dut (
        .clk(clk), .aclr(aclr), .flush(flush), .DataIn(DataIn), .InValid(InValid),
        .InReady(InReady), .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady),
        .Count(Count)
    );

    always #5 clk = ~clk;

    // Model: oldest word first; mPos is the stage index each word sits in.
    int mData[$];
    int mPos[$];
    int got[$];
    bit rdy;

    typedef struct {
        bit a, f, iv;
        int d;
        bit ordy;
        bit eRdy, eOV;
        int eD;
        int eCnt;
        bit chkD;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit modelOutValid();
        return mData.size() > 0 && mPos[0] == S - 1;
    endfunction

    // One clock: drive at negedge, check InReady, update model on the edge, check registered outputs.
    task automatic tick(input bit a, input bit f, input bit iv, input int d, input bit ordy, output bit r);
        bit expRdy;
        bit mOV;
        int limit;
        int np;
        aclr = a; flush = f; InValid = iv; DataIn = d[W-1:0]; OutReady = ordy;
        #1;
        expRdy = !a && !f && (mData.size() < S || ordy);
        r = InReady;
        chk("InReady", InReady, expRdy);
        @(posedge clk);
        mOV = modelOutValid();
        if (a || f) begin
            mData.delete();
            mPos.delete();
        end else begin
            if (mOV && ordy) begin
                void'(mData.pop_front());
                void'(mPos.pop_front());
            end
            limit = S - 1;
            foreach (mPos[k]) begin
                np = (mPos[k] + 1 < limit) ? mPos[k] + 1 : limit;
                mPos[k] = np;
                limit = np - 1;
            end
            if (iv && expRdy) begin
                mData.push_back(d & 'hFF);
                mPos.push_back(0);
            end
        end
        #1;
        mOV = modelOutValid();
        chk("OutValid", OutValid, mOV);
        chk("Count", Count, mData.size());
        if (mOV) chk("DataOut", DataOut, mData[0]);
        if (a) chk("DataOut_rst", DataOut, 0);
        @(negedge clk);
    endtask

    function automatic void addv(bit a, bit f, bit iv, int d, bit ordy,
                                 bit eRdy, bit eOV, int eD, int eCnt, bit chkD);
        vec_t v;
        v.a = a; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eRdy = eRdy; v.eOV = eOV; v.eD = eD; v.eCnt = eCnt; v.chkD = chkD;
        tbl.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int firstCyc;
        int lastCyc;
        int lowRdy;
        bit ov;
        int dat;
        bit a, f, iv, ordy;

        // Single word latency, then consumption.
        addv(1,0,0,0,   1, 0,0,0,    0,1);
        addv(0,0,1,'h11,1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,1,'h11, 1,1);
        addv(0,0,0,0,   1, 1,0,0,    0,0);
        // Four words held, flush with a concurrent input.
        addv(0,0,1,'hA1,0, 1,0,0,    1,0);
        addv(0,0,1,'hA2,0, 1,0,0,    2,0);
        addv(0,0,1,'hA3,0, 1,0,0,    3,0);
        addv(0,0,1,'hA4,0, 1,0,0,    4,0);
        addv(0,1,1,'hFF,0, 0,0,0,    0,0);
        addv(0,0,0,0,   1, 1,0,0,    0,0);
        // Three words held, reset mid-stream, then latency of the next word.
        addv(0,0,1,'hB1,0, 1,0,0,    1,0);
        addv(0,0,1,'hB2,0, 1,0,0,    2,0);
        addv(0,0,1,'hB3,0, 1,0,0,    3,0);
        addv(1,0,1,'h77,1, 0,0,0,    0,1);
        addv(0,0,1,'hC5,1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,0,0,    1,0);
        addv(0,0,0,0,   1, 1,1,'hC5, 1,1);
        addv(0,0,0,0,   1, 1,0,0,    0,0);

        @(negedge clk);
        foreach (tbl[i]) begin
            tick(tbl[i].a, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy, rdy);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].eRdy);
            chk($sformatf("tbl%0d_ov", i), OutValid, tbl[i].eOV);
            chk($sformatf("tbl%0d_cnt", i), Count, tbl[i].eCnt);
            if (tbl[i].chkD) chk($sformatf("tbl%0d_dat", i), DataOut, tbl[i].eD);
        end

        // Streaming 0x00..0x3F with OutReady held high.
        tick(1,0,0,0,1,rdy);
        got.delete(); lowRdy = 0; firstCyc = -1; lastCyc = -1;
        for (int i = 0; i < 72; i++) begin
            if (OutValid) begin
                got.push_back(DataOut);
                if (firstCyc < 0) firstCyc = i;
                lastCyc = i;
            end
            tick(0,0,i < 64, i, 1, rdy);
            if (i < 64 && !rdy) lowRdy++;
        end
        chk("stream_rdy_low", lowRdy, 0);
        chk("stream_n", got.size(), 64);
        chk("stream_span", lastCyc - firstCyc, 63);
        foreach (got[k]) chk($sformatf("stream_w%0d", k), got[k], k);

        // Fill with OutReady low, then one-in/one-out when full.
        tick(1,0,0,0,0,rdy);
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            tick(0,0,1,'h40 + i,0,rdy);
            if (rdy) acc++;
        end
        chk("full_acc", acc, 5);
        chk("full_cnt", Count, 5);
        chk("full_ov", OutValid, 1);
        chk("full_dat", DataOut, 'h40);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            if (OutValid) got.push_back(DataOut);
            tick(0,0,1,'h50 + i,1,rdy);
            chk($sformatf("ioio_rdy%0d", i), rdy, 1);
            chk($sformatf("ioio_cnt%0d", i), Count, 5);
        end
        chk("ioio_n", got.size(), 6);
        for (int k = 0; k < 5; k++) chk($sformatf("ioio_w%0d", k), got[k], 'h40 + k);
        chk("ioio_w5", got[5], 'h50);

        // Three words drained with OutReady toggling.
        tick(1,0,0,0,0,rdy);
        for (int i = 0; i < 3; i++) tick(0,0,1,'h60 + i,0,rdy);
        got.delete();
        for (int i = 0; i < 16; i++) begin
            ordy = (i % 2 == 0);
            ov = OutValid;
            dat = DataOut;
            tick(0,0,0,0,ordy,rdy);
            if (ov && ordy) got.push_back(dat);
        end
        chk("drain_cnt", Count, 0);
        chk("drain_n", got.size(), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("drain_w%0d", k), got[k], 'h60 + k);

        // Random traffic against the model.
        tick(1,0,0,0,0,rdy);
        for (int n = 0; n < 3000; n++) begin
            a    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 59) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < (((n / 500) % 2 == 1) ? 8 : 3));
            tick(a, f, iv, $urandom_range(0, 255), ordy, rdy);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
